// File: rtl/keccak_pkg.sv
// Shared Keccak types and constants for the chi step and its neighbours.
package keccak_pkg;

    localparam int KECCAK_DIM    = 5;
    localparam int CHI_ROWS      = 5;
    localparam int KECCAK_LANE_W = 64;

    typedef logic [KECCAK_LANE_W-1:0] lane_t;
    typedef lane_t [KECCAK_DIM-1:0][KECCAK_DIM-1:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        DONE = 2'd2
    } chi_state_t;

endpackage

// File: rtl/chi_row.sv
// Combinational chi on one row: out[x] = in[x] ^ (~in[x+1] & in[x+2]), indices mod 5.
module chi_row
    import keccak_pkg::*;
#(
    parameter int LANE_W = 64
) (
    input  logic [KECCAK_DIM-1:0][LANE_W-1:0] lanes_in,
    output logic [KECCAK_DIM-1:0][LANE_W-1:0] lanes_out
);

    for (genvar x = 0; x < KECCAK_DIM; x++) begin : g_lane
        assign lanes_out[x] = lanes_in[x]
                            ^ (~lanes_in[(x + 1) % KECCAK_DIM] & lanes_in[(x + 2) % KECCAK_DIM]);
    end

endmodule

// File: rtl/chi_step.sv
// Keccak chi step with ready/valid handshake; row-serial by default, all rows
// in one cycle when CHI_STEP_PARALLEL_EN is defined.
module chi_step
    import keccak_pkg::*;
#(
    parameter int LANE_W = 64
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    output logic                                          in_ready,
    input  logic [KECCAK_DIM-1:0][KECCAK_DIM-1:0][LANE_W-1:0] state_in,
    input  logic [31:0]                                   round_in,
    output logic                                          valid,
    input  logic                                          out_ready,
    output logic [KECCAK_DIM-1:0][KECCAK_DIM-1:0][LANE_W-1:0] state_out,
    output logic [31:0]                                   round_out
);

    chi_state_t st, st_nxt;
    logic [KECCAK_DIM-1:0][KECCAK_DIM-1:0][LANE_W-1:0] buffer;
    logic [31:0] round_q;

`ifdef CHI_STEP_PARALLEL_EN
    logic [KECCAK_DIM-1:0][KECCAK_DIM-1:0][LANE_W-1:0] chi_all;

    for (genvar y = 0; y < CHI_ROWS; y++) begin : g_row
        logic [KECCAK_DIM-1:0][LANE_W-1:0] row_in, row_out;
        for (genvar x = 0; x < KECCAK_DIM; x++) begin : g_col
            assign row_in[x]     = buffer[x][y];
            assign chi_all[x][y] = row_out[x];
        end
        chi_row #(.LANE_W(LANE_W)) u_row (
            .lanes_in  (row_in),
            .lanes_out (row_out)
        );
    end
`else
    localparam logic [2:0] LAST_ROW = 3'(CHI_ROWS - 1);

    logic [2:0] row_cnt;
    logic [KECCAK_DIM-1:0][LANE_W-1:0] row_in, row_out;

    always_comb begin
        row_in = '0;
        for (int x = 0; x < KECCAK_DIM; x++)
            row_in[x] = buffer[x][row_cnt];
    end

    chi_row #(.LANE_W(LANE_W)) u_row (
        .lanes_in  (row_in),
        .lanes_out (row_out)
    );
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) st <= IDLE;
        else        st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            IDLE: if (start) st_nxt = PROC;
`ifdef CHI_STEP_PARALLEL_EN
            PROC: st_nxt = DONE;
`else
            PROC: if (row_cnt == LAST_ROW) st_nxt = DONE;
`endif
            DONE: if (out_ready) st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    // Rows are rewritten in place so the buffer doubles as the output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buffer  <= '0;
            round_q <= '0;
`ifndef CHI_STEP_PARALLEL_EN
            row_cnt <= '0;
`endif
        end else begin
            case (st)
                IDLE: if (start) begin
                    buffer  <= state_in;
                    round_q <= round_in;
`ifndef CHI_STEP_PARALLEL_EN
                    row_cnt <= '0;
`endif
                end
                PROC: begin
`ifdef CHI_STEP_PARALLEL_EN
                    buffer <= chi_all;
`else
                    for (int x = 0; x < KECCAK_DIM; x++)
                        buffer[x][row_cnt] <= row_out[x];
                    row_cnt <= (row_cnt == LAST_ROW) ? 3'd0 : row_cnt + 3'd1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (st == IDLE);
    assign valid     = (st == DONE);
    assign state_out = buffer;
    assign round_out = round_q;

endmodule

// File: tb/tb_chi_step.sv
// Directed self-checking bench for chi_step (either build of CHI_STEP_PARALLEL_EN).
module tb_chi_step;

    typedef logic [4:0][4:0][63:0] st_t;

`ifdef CHI_STEP_PARALLEL_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 5;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_ready;
    st_t         state_in = '0;
    logic [31:0] round_in = '0;
    logic        valid;
    logic        out_ready = 1'b0;
    st_t         state_out;
    logic [31:0] round_out;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    chi_step #(.LANE_W(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .round_in  (round_in),
        .valid     (valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .round_out (round_out)
    );

    function automatic st_t chi_ref(input st_t s);
        st_t o;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                o[x][y] = s[x][y] ^ (~s[(x + 1) % 5][y] & s[(x + 2) % 5][y]);
        return o;
    endfunction

    // Accept one transaction and wait (bounded) for valid; returns cycles to valid.
    task automatic launch(input st_t s, input logic [31:0] r, output int lat);
        @(negedge clk);
        state_in = s;
        round_in = r;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (!valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_chk++;
        if (valid !== 1'b0 || state_out !== '0 || round_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b round_out=%0d state_or=%b, required 0/0/0",
                     valid, round_out, |state_out);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_chk++;
        if (in_ready !== 1'b1 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: in_ready=%b valid=%b, required 1/0", in_ready, valid);
        end
    endtask

    task automatic test_zero();
        int lat;
        launch('0, 32'd3, lat);
        n_chk++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL zero_latency: got %0d cycles, required %0d", lat, LAT);
        end
        n_chk++;
        if (state_out !== '0 || round_out !== 32'd3) begin
            n_fail++;
            $display("FAIL zero_result: round_out=%0d nonzero=%b, required 3/0", round_out, |state_out);
        end
        release_out();
        n_chk++;
        if (valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_release: valid=%b in_ready=%b, required 0/1", valid, in_ready);
        end
    endtask

    task automatic test_ones();
        int lat;
        st_t ones;
        ones = '1;
        launch(ones, 32'd30, lat);
        n_chk++;
        if (state_out !== ones || round_out !== 32'd30) begin
            n_fail++;
            $display("FAIL ones_result: round_out=%0d allones=%b, required 30/1", round_out, &state_out);
        end
        release_out();
    endtask

    task automatic test_row0();
        int lat;
        st_t s, exp;
        s = '0;
        s[2][0] = '1;
        exp = '0;
        exp[0][0] = '1;
        exp[2][0] = '1;
        launch(s, 32'd0, lat);
        n_chk++;
        if (state_out !== exp) begin
            n_fail++;
            $display("FAIL row0_result: out[0][0]=%h out[1][0]=%h out[2][0]=%h required ones/0/ones",
                     state_out[0][0], state_out[1][0], state_out[2][0]);
        end
        release_out();
    endtask

    task automatic test_stall();
        int lat;
        st_t s, exp, other;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                s[x][y] = 64'h0123_4567_89AB_CDEF ^ {32'(x * 7 + 1), 32'(y * 13 + 5)};
        exp = chi_ref(s);
        other = ~s;
        launch(s, 32'd7, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start    = (i % 3 == 0);
            state_in = other;
            round_in = 32'd99;
        end
        @(negedge clk);
        start = 1'b0;
        n_chk++;
        if (valid !== 1'b1 || in_ready !== 1'b0 || state_out !== exp || round_out !== 32'd7) begin
            n_fail++;
            $display("FAIL stall_hold: valid=%b in_ready=%b round_out=%0d data_ok=%b, required 1/0/7/1",
                     valid, in_ready, round_out, state_out === exp);
        end
        // start coinciding with the DONE->IDLE edge must not be taken
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        start     = 1'b0;
        n_chk++;
        if (valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: valid=%b in_ready=%b, required 0/1", valid, in_ready);
        end
        @(posedge clk);
        #1;
        n_chk++;
        if (in_ready !== 1'b1 || round_out !== 32'd7) begin
            n_fail++;
            $display("FAIL exit_start_ignored: in_ready=%b round_out=%0d, required 1/7", in_ready, round_out);
        end
        // out_ready while idle does nothing
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_chk++;
        if (valid !== 1'b0 || in_ready !== 1'b1 || state_out !== exp) begin
            n_fail++;
            $display("FAIL idle_out_ready: valid=%b in_ready=%b, required 0/1", valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        st_t s, ones;
        s = '0;
        s[1][3] = 64'hFFFF_0000_FFFF_0000;
        s[2][3] = 64'h0F0F_0F0F_0F0F_0F0F;
        ones = '1;
        @(negedge clk);
        state_in = s;
        round_in = 32'd11;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (LAT > 2) begin
            repeat (2) @(posedge clk);
            #1;
        end
        reset = 1'b0;
        #2;
        n_chk++;
        if (valid !== 1'b0 || state_out !== '0 || round_out !== '0) begin
            n_fail++;
            $display("FAIL midreset_clear: valid=%b round_out=%0d nonzero=%b, required 0/0/0",
                     valid, round_out, |state_out);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (valid !== 1'b0 || in_ready !== 1'b1 || state_out !== '0) begin
            n_fail++;
            $display("FAIL midreset_discard: valid=%b in_ready=%b, required 0/1", valid, in_ready);
        end
        launch(ones, 32'd2, lat);
        n_chk++;
        if (lat !== LAT || state_out !== ones || round_out !== 32'd2) begin
            n_fail++;
            $display("FAIL midreset_rerun: lat=%0d round_out=%0d allones=%b, required %0d/2/1",
                     lat, round_out, &state_out, LAT);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        int lat;
        st_t s, exp;
        logic [31:0] rnd;
        for (int t = 0; t < 12; t++) begin
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    s[x][y] = {$urandom(), $urandom()};
            rnd = 32'(t * 5 + 20);
            exp = chi_ref(s);
            launch(s, rnd, lat);
            n_chk++;
            if (lat !== LAT || state_out !== exp || round_out !== rnd) begin
                n_fail++;
                $display("FAIL b2b_%0d: lat=%0d round_out=%0d data_ok=%b, required %0d/%0d/1",
                         t, lat, round_out, state_out === exp, LAT, rnd);
            end
            repeat (t % 3) @(negedge clk);
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_ones();
        test_row0();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
